fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_seq_pkg.sv | 23 ++
 rtl/fetch_sequencer_wait_counter.sv | 39 +++
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 tb/tb_fetch_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, opcode values
// and the wait-counter width.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam int unsigned WAIT_W = 4;

    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_WAIT = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Opcode used on resume from HALT so that EXEC issues a plain step.
    localparam logic [3:0] OP_NOP  = 4'h0;

endpackage

// File: rtl/fetch_sequencer_wait_counter.sv
// Saturating down-counter for the WAIT instruction: synchronous load and
// decrement, with a zero flag that the sequencer uses to end the wait.
import fetch_seq_pkg::*;

module wait_counter (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic [WAIT_W-1:0] count,
    output logic              zero
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Decrement stops at zero, so the counter can never wrap.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steps FETCH/DECODE/EXEC, handles jump, timed
// wait and halt opcodes, and drives the external PC and fetch register.
import fetch_seq_pkg::*;

module fetch_sequencer #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic [3:0]        instr,
    input  logic [3:0]        oprnd,
    output logic              pc_en,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_data,
    output logic              fetch_en,
    output logic              busy,
    output logic              halted
);

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [3:0]        arg_q, arg_d;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic [WAIT_W-1:0] cnt_value;

    wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (arg_q),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            arg_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
        end
    end

    // Outputs depend only on registered state, so inputs never reach them combinationally.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        arg_d    = arg_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        pc_en    = 1'b0;
        pc_load  = 1'b0;
        pc_data  = '0;
        fetch_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fetch_en = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                op_d    = instr;
                arg_d   = oprnd;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_JMP: begin
                        pc_load = 1'b1;
                        pc_data = ADDR_W'({arg_q, 8'h00});
                        state_d = halt_req ? ST_IDLE : ST_FETCH;
                    end
                    OP_WAIT: begin
                        cnt_load = 1'b1;
                        state_d  = ST_WAIT;
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        pc_en   = 1'b1;
                        state_d = halt_req ? ST_IDLE : ST_FETCH;
                    end
                endcase
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    pc_en   = 1'b1;
                    state_d = halt_req ? ST_IDLE : ST_FETCH;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_HALT: begin
                // Resume re-enters EXEC as a plain step so the HALT word is skipped.
                if (start) begin
                    op_d    = OP_NOP;
                    arg_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: walks plain, jump, wait, halt,
// halt_req and mid-wait reset sequences with hand-computed expected outputs.
module tb_fetch_sequencer;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              reset;
    logic              start;
    logic              halt_req;
    logic [3:0]        instr;
    logic [3:0]        oprnd;
    logic              pc_en;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_data;
    logic              fetch_en;
    logic              busy;
    logic              halted;

    int checks;
    int errors;

    fetch_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .halt_req (halt_req),
        .instr    (instr),
        .oprnd    (oprnd),
        .pc_en    (pc_en),
        .pc_load  (pc_load),
        .pc_data  (pc_data),
        .fetch_en (fetch_en),
        .busy     (busy),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {pc_en, pc_load, fetch_en, busy, halted, pc_data}.
    function automatic logic [16:0] outs();
        return {pc_en, pc_load, fetch_en, busy, halted, pc_data};
    endfunction

    function automatic logic [16:0] expv(input logic pe, input logic pl, input logic fe,
                                         input logic b, input logic h,
                                         input logic [11:0] d);
        return {pe, pl, fe, b, h, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [16:0] actual,
                               input logic [16:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h (pe,pl,fe,busy,halt,data) expected %h",
                     tag, actual, expected);
        end
    endtask

    // Drive inputs, then advance one rising edge and settle 1 time unit past it.
    task automatic applyStimulus(input logic s, input logic h,
                                 input logic [3:0] i, input logic [3:0] o);
        start    = s;
        halt_req = h;
        instr    = i;
        oprnd    = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        halt_req = 1'b0;
        instr    = 4'h0;
        oprnd    = 4'h0;

        applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0);
        checkOutput("reset_state", outs(), expv(0, 0, 0, 0, 0, 12'h000));
        reset = 1'b0;

        // Plain instruction: fetch_en at t+1, pc_en at t+3, fetch_en at t+4.
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h0);
        checkOutput("plain_fetch", outs(), expv(0, 0, 1, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'h3, 4'h0);
        checkOutput("plain_decode", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'h3, 4'h0);
        checkOutput("plain_exec", outs(), expv(1, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hE, 4'h5);
        checkOutput("plain_refetch", outs(), expv(0, 0, 1, 1, 0, 12'h000));

        // Jump to {5, 8'h00}.
        applyStimulus(1'b0, 1'b0, 4'hE, 4'h5);
        checkOutput("jmp_decode", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hE, 4'h5);
        checkOutput("jmp_exec", outs(), expv(0, 1, 0, 1, 0, 12'h500));
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h3);
        checkOutput("jmp_fetch", outs(), expv(0, 0, 1, 1, 0, 12'h000));

        // Wait 3: four WAIT cycles, start held high and ignored meanwhile.
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h3);
        checkOutput("wait3_decode", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h3);
        checkOutput("wait3_exec", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 4'hC, 4'h3);
            checkOutput($sformatf("wait3_cycle%0d", i), outs(),
                        expv((i == 3), 0, 0, 1, 0, 12'h000));
        end
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h0);
        checkOutput("wait3_fetch", outs(), expv(0, 0, 1, 1, 0, 12'h000));

        // Wait 0: a single WAIT cycle carrying pc_en.
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h0);
        checkOutput("wait0_decode", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h0);
        checkOutput("wait0_exec", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0);
        checkOutput("wait0_cycle", outs(), expv(1, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0);
        checkOutput("wait0_fetch", outs(), expv(0, 0, 1, 1, 0, 12'h000));

        // Halt, idle there for 10 cycles, then resume.
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0);
        checkOutput("halt_decode", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hF, 4'h0);
        checkOutput("halt_exec", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 4'hF, 4'h0);
            checkOutput($sformatf("halt_hold%0d", i), outs(), expv(0, 0, 0, 0, 1, 12'h000));
        end
        applyStimulus(1'b1, 1'b0, 4'h3, 4'h0);
        checkOutput("resume_exec", outs(), expv(1, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'h3, 4'h0);
        checkOutput("resume_fetch", outs(), expv(0, 0, 1, 1, 0, 12'h000));

        // halt_req during a plain instruction: pc_en, then IDLE.
        applyStimulus(1'b0, 1'b1, 4'h3, 4'h0);
        checkOutput("hreq_decode", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b1, 4'h3, 4'h0);
        checkOutput("hreq_exec", outs(), expv(1, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b1, 4'h3, 4'h0);
        checkOutput("hreq_idle", outs(), expv(0, 0, 0, 0, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'h3, 4'h0);
        checkOutput("hreq_idle_hold", outs(), expv(0, 0, 0, 0, 0, 12'h000));

        // Reset on the 2nd WAIT cycle of wait 7, overriding a held start.
        applyStimulus(1'b1, 1'b0, 4'hC, 4'h7);
        checkOutput("rstw_fetch", outs(), expv(0, 0, 1, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h7);
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h7);
        checkOutput("rstw_exec", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h7);
        checkOutput("rstw_wait1", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        applyStimulus(1'b0, 1'b0, 4'hC, 4'h7);
        checkOutput("rstw_wait2", outs(), expv(0, 0, 0, 1, 0, 12'h000));
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'hC, 4'h7);
        checkOutput("rstw_idle", outs(), expv(0, 0, 0, 0, 0, 12'h000));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0, 4'h0);
            checkOutput($sformatf("rstw_quiet%0d", i), outs(), expv(0, 0, 0, 0, 0, 12'h000));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
